// File: rtl/pipeline_issue_controller_if.sv
// Fetch-side byte handshake between the opcode buffer and the issue controller.
interface pipeline_issue_controller_if;
  logic       op_valid;
  logic [7:0] op_byte;
  logic       fetch_hold;

  // Fetch/opcode buffer side
  modport master (output op_valid, output op_byte, input fetch_hold);
  // Issue controller side
  modport slave  (input op_valid, input op_byte, output fetch_hold);
endinterface

// File: rtl/pipeline_issue_controller.sv
// Pipeline issue controller: assembles one/two-byte instructions from fetch,
// issues opcodes to the stage-2 control generator and sequences bubbles for
// BB2 holds, load-use stalls and stage-4 PC-load flushes.
module pipeline_issue_controller #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  pipeline_issue_controller_if.slave    fetch,
  input  logic                          bb2,
  input  logic                          lpc_taken,
  input  logic                          ld_pend,
  input  logic [2:0]                    ld_dest,
  output logic [7:0]                    opcode_out,
  output logic                          bb,
  output logic [7:0]                    od_out,
  output logic                          od_valid,
  output logic                          flush_active,
  output logic [CNT_W-1:0]              bubble_cnt
);

  typedef enum logic [1:0] {
    DECODE  = 2'd0,
    OPERAND = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t     state;
  logic       hold_r;
  logic [2:0] flush_cnt;
  logic [7:0] op_latch;

  logic       needs_od;
  logic       uses_rn;
  logic       load_use;
  logic [4:0] op_hi;

  // Instruction-length and register-use predicates on the presented byte
  always_comb begin
    op_hi    = fetch.op_byte[7:3];
    needs_od = (fetch.op_byte == 8'h03) || (fetch.op_byte == 8'h05) ||
               (op_hi == 5'b00001) || (op_hi == 5'b00110) ||
               (op_hi == 5'b01011) || (op_hi == 5'b01110) ||
               (fetch.op_byte[7] && fetch.op_byte[3] && (op_hi != 5'b11111));
    uses_rn  = (fetch.op_byte[7:4] != 4'h0);
    load_use = ld_pend && uses_rn &&
               ((ld_dest == fetch.op_byte[2:0]) || (ld_dest == 3'd0));
  end

  // Fetch must keep its byte while a BB2 hold or load-use stall is pending
  always_comb begin
    fetch.fetch_hold = (state == DECODE) && fetch.op_valid && (hold_r || load_use);
  end

  // Issue sequencing, flush counting and bubble performance counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= DECODE;
      opcode_out   <= '0;
      bb           <= 1'b1;
      od_out       <= '0;
      od_valid     <= 1'b0;
      flush_active <= 1'b0;
      bubble_cnt   <= '0;
      hold_r       <= 1'b0;
      flush_cnt    <= '0;
      op_latch     <= '0;
    end else begin
      if (bb && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end

      hold_r <= 1'b0;

      if (lpc_taken) begin
        // A taken PC load drops any byte on offer and any half-built instruction
        state        <= FLUSH;
        flush_cnt    <= 3'(FLUSH_CYCLES - 1);
        flush_active <= 1'b1;
        bb           <= 1'b1;
        opcode_out   <= '0;
        od_valid     <= 1'b0;
      end else begin
        case (state)
          DECODE: begin
            hold_r   <= bb2;
            od_valid <= 1'b0;
            if (hold_r) begin
              bb <= 1'b1;
            end else if (!fetch.op_valid || load_use) begin
              bb         <= 1'b1;
              opcode_out <= '0;
            end else if (needs_od) begin
              op_latch   <= fetch.op_byte;
              bb         <= 1'b1;
              opcode_out <= '0;
              state      <= OPERAND;
            end else begin
              opcode_out <= fetch.op_byte;
              bb         <= 1'b0;
            end
          end

          OPERAND: begin
            hold_r <= bb2;
            if (fetch.op_valid) begin
              opcode_out <= op_latch;
              od_out     <= fetch.op_byte;
              od_valid   <= 1'b1;
              bb         <= 1'b0;
              state      <= DECODE;
            end else begin
              bb         <= 1'b1;
              opcode_out <= '0;
              od_valid   <= 1'b0;
            end
          end

          FLUSH: begin
            bb         <= 1'b1;
            opcode_out <= '0;
            od_valid   <= 1'b0;
            if (flush_cnt == '0) begin
              state        <= DECODE;
              flush_active <= 1'b0;
            end else begin
              flush_cnt <= flush_cnt - 3'd1;
            end
          end

          default: begin
            state        <= DECODE;
            bb           <= 1'b1;
            opcode_out   <= '0;
            od_valid     <= 1'b0;
            flush_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipeline_issue_controller.sv
// Self-checking bench for pipeline_issue_controller with a per-cycle
// expected-output scoreboard.
module tb_pipeline_issue_controller;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk;
  logic             rst;
  logic             bb2;
  logic             lpc_taken;
  logic             ld_pend;
  logic [2:0]       ld_dest;
  logic [7:0]       opcode_out;
  logic             bb;
  logic [7:0]       od_out;
  logic             od_valid;
  logic             flush_active;
  logic [CNT_W-1:0] bubble_cnt;

  pipeline_issue_controller_if fif ();

  pipeline_issue_controller #(
    .FLUSH_CYCLES (2),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch        (fif),
    .bb2          (bb2),
    .lpc_taken    (lpc_taken),
    .ld_pend      (ld_pend),
    .ld_dest      (ld_dest),
    .opcode_out   (opcode_out),
    .bb           (bb),
    .od_out       (od_out),
    .od_valid     (od_valid),
    .flush_active (flush_active),
    .bubble_cnt   (bubble_cnt)
  );

  typedef struct packed {
    logic             bb;
    logic [7:0]       op;
    logic [7:0]       od;
    logic             odv;
    logic             fa;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sbq[$];
  int               total = 0;
  int               bad   = 0;
  logic             m_bb;
  logic [CNT_W-1:0] m_cnt;
  logic [7:0]       exp_od;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check fetch_hold for the inputs just driven, before the next edge
  task automatic fh(input logic e);
    #1;
    check("fetch_hold", fif.fetch_hold, e);
  endtask

  // Push the expected post-edge outputs, clock once, pop and compare
  task automatic cyc(input logic e_bb, input logic [7:0] e_op, input logic e_odv, input logic e_fa);
    exp_t e;
    exp_t o;
    if (m_bb && (m_cnt != CNT_MAX)) m_cnt = m_cnt + 1'b1;
    e.bb  = e_bb;
    e.op  = e_op;
    e.od  = exp_od;
    e.odv = e_odv;
    e.fa  = e_fa;
    e.cnt = m_cnt;
    m_bb  = e_bb;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    o = sbq.pop_front();
    check("bb", bb, o.bb);
    check("opcode_out", opcode_out, o.op);
    check("od_out", od_out, o.od);
    check("od_valid", od_valid, o.odv);
    check("flush_active", flush_active, o.fa);
    check("bubble_cnt", bubble_cnt, o.cnt);
  endtask

  task automatic drive(input logic v, input logic [7:0] b);
    fif.op_valid = v;
    fif.op_byte  = b;
  endtask

  task automatic check_reset_state();
    check("rst_bb", bb, 1'b1);
    check("rst_opcode", opcode_out, 8'h00);
    check("rst_od", od_out, 8'h00);
    check("rst_odv", od_valid, 1'b0);
    check("rst_fa", flush_active, 1'b0);
    check("rst_cnt", bubble_cnt, '0);
    m_bb   = 1'b1;
    m_cnt  = '0;
    exp_od = 8'h00;
  endtask

  initial begin
    rst       = 1'b1;
    bb2       = 1'b0;
    lpc_taken = 1'b0;
    ld_pend   = 1'b0;
    ld_dest   = 3'd0;
    drive(1'b0, 8'h00);
    #2;
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset: bubbles counted
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h00, 1'b0, 1'b0);
    check("idle_cnt5", bubble_cnt, 16'd5);

    // Back-to-back single-byte instructions
    drive(1'b1, 8'h41); fh(1'b0); cyc(1'b0, 8'h41, 1'b0, 1'b0);
    drive(1'b1, 8'h21); fh(1'b0); cyc(1'b0, 8'h21, 1'b0, 1'b0);
    drive(1'b0, 8'h00);           cyc(1'b1, 8'h00, 1'b0, 1'b0);

    // Two-byte instruction with a two-cycle gap before the operand
    drive(1'b1, 8'h8B); fh(1'b0); cyc(1'b1, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00);           cyc(1'b1, 8'h00, 1'b0, 1'b0);
                                  cyc(1'b1, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h5A); fh(1'b0); exp_od = 8'h5A;
                                  cyc(1'b0, 8'h8B, 1'b1, 1'b0);
    drive(1'b0, 8'h00);           cyc(1'b1, 8'h00, 1'b0, 1'b0);

    // Load-use stall on matching destination, none on other destination
    ld_pend = 1'b1; ld_dest = 3'd3; drive(1'b1, 8'h43);
    for (int i = 0; i < 3; i++) begin
      fh(1'b1); cyc(1'b1, 8'h00, 1'b0, 1'b0);
    end
    ld_pend = 1'b0; fh(1'b0); cyc(1'b0, 8'h43, 1'b0, 1'b0);
    ld_pend = 1'b1; ld_dest = 3'd5; fh(1'b0); cyc(1'b0, 8'h43, 1'b0, 1'b0);
    ld_dest = 3'd0; drive(1'b1, 8'h21); fh(1'b1); cyc(1'b1, 8'h00, 1'b0, 1'b0);
    ld_pend = 1'b0; drive(1'b0, 8'h00); cyc(1'b1, 8'h00, 1'b0, 1'b0);

    // Flush during OPERAND: partial 03 discarded, bytes dropped
    drive(1'b1, 8'h03); fh(1'b0); cyc(1'b1, 8'h00, 1'b0, 1'b0);
    lpc_taken = 1'b1; drive(1'b1, 8'h77); fh(1'b0); cyc(1'b1, 8'h00, 1'b0, 1'b1);
    lpc_taken = 1'b0; drive(1'b1, 8'h41); fh(1'b0); cyc(1'b1, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00);                           cyc(1'b1, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h21); fh(1'b0);                 cyc(1'b0, 8'h21, 1'b0, 1'b0);
    drive(1'b0, 8'h00);                           cyc(1'b1, 8'h00, 1'b0, 1'b0);

    // Flush reload and bb2 ignored during flush
    lpc_taken = 1'b1; cyc(1'b1, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h00, 1'b0, 1'b1);
    lpc_taken = 1'b0; bb2 = 1'b1; cyc(1'b1, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'h00, 1'b0, 1'b0);
    bb2 = 1'b0; drive(1'b1, 8'h41); fh(1'b0); cyc(1'b0, 8'h41, 1'b0, 1'b0);

    // BB2 hold: one bubble, byte held, opcode retained
    drive(1'b1, 8'h80); fh(1'b0); cyc(1'b0, 8'h80, 1'b0, 1'b0);
    bb2 = 1'b1; drive(1'b1, 8'h41); fh(1'b0); cyc(1'b0, 8'h41, 1'b0, 1'b0);
    bb2 = 1'b0; drive(1'b1, 8'h21); fh(1'b1); cyc(1'b1, 8'h41, 1'b0, 1'b0);
    fh(1'b0); cyc(1'b0, 8'h21, 1'b0, 1'b0);
    drive(1'b0, 8'h00); cyc(1'b1, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset in OPERAND discards the opcode
    drive(1'b1, 8'h03); fh(1'b0); cyc(1'b1, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00);
    rst = 1'b1;
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 8'h21); fh(1'b0); cyc(1'b0, 8'h21, 1'b0, 1'b0);
    drive(1'b1, 8'h5A); fh(1'b0); cyc(1'b1, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h11); fh(1'b0); exp_od = 8'h11; cyc(1'b0, 8'h5A, 1'b1, 1'b0);

    // Bubble counter saturation
    drive(1'b0, 8'h00);
    for (int i = 0; i < 70000 && m_cnt != CNT_MAX; i++) cyc(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h00, 1'b0, 1'b0);
    check("cnt_saturated", bubble_cnt, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
